// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: re-encodes decoded MIPS fields and streams the words into imem through a small FIFO
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  input  logic              mem_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t            state_q;
  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       occ_q;
  logic [ADDR_W-1:0] addr_q, count_q;
  logic              err_q;
  logic [5:0]        op;
  logic [31:0]       enc;
  logic              legal, full, empty, active, accept, push, pop;
  assign op     = in_kind == 3'd1 ? 6'h23 : in_kind == 3'd2 ? 6'h2b : in_kind == 3'd3 ? 6'h04 : 6'h08;
  assign enc    = in_kind == 3'd0 ? {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct}
                : in_kind == 3'd5 ? {6'h02, in_target} : {op, in_rs, in_rt, in_imm};
  assign legal  = in_kind < 3'd6;
  assign full   = occ_q == (PW+1)'(DEPTH);
  assign empty  = occ_q == '0;
  assign active = state_q == LOAD || state_q == FLUSH;
  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = imem_we;
  assign in_ready   = state_q == LOAD && !full;
  assign imem_we    = !empty && mem_ready && active;
  // head is forced to zero while empty so the output never exposes stale or unwritten storage
  assign imem_wdata = empty ? 32'h0 : mem_q[rd_q];
  assign imem_addr  = addr_q;
  assign busy       = active;
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign count      = count_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= enc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      occ_q <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
      if (pop) addr_q <= addr_q + ADDR_W'(4);
      if (pop) count_q <= count_q + ADDR_W'(1);
      if (accept && !legal) err_q <= 1'b1;
      if ((state_q == IDLE || state_q == DONE) && start) begin
        state_q <= LOAD;
        addr_q  <= ADDR_W'(BASE_ADDR);
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (state_q == LOAD && accept && in_last) state_q <= FLUSH;
      else if (state_q == FLUSH && empty) state_q <= DONE;
    end
  end
endmodule
